// File: rtl/audio_mixer_if.sv
// audio_mixer_if: source/volume inputs, frame strobe and mixed stereo outputs of the mixer
interface audio_mixer_if #(
  parameter int NUM_SRC = 4,
  parameter int IN_W = 16,
  parameter int VOL_W = 6,
  parameter int OUT_W = 24
);
  logic next_sample;
  logic [NUM_SRC*IN_W-1:0] src_left;
  logic [NUM_SRC*IN_W-1:0] src_right;
  logic [NUM_SRC*VOL_W-1:0] src_volume;
  logic [NUM_SRC-1:0] src_mute;
  logic overrun_clr;
  logic [OUT_W-1:0] left_data;
  logic [OUT_W-1:0] right_data;
  logic out_valid;
  logic busy;
  logic overrun;
  modport master(
    output next_sample, src_left, src_right, src_volume, src_mute, overrun_clr,
    input left_data, right_data, out_valid, busy, overrun
  );
  modport slave(
    input next_sample, src_left, src_right, src_volume, src_mute, overrun_clr,
    output left_data, right_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/audio_mixer.sv
// audio_mixer: N-source stereo volume/mute mixer, one shared MAC, saturated left-justified output
module audio_mixer #(
  parameter int NUM_SRC = 4,
  parameter int IN_W = 16,
  parameter int VOL_W = 6,
  parameter int OUT_W = 24
) (
  input logic clk,
  input logic rst,
  audio_mixer_if.slave bus
);
  localparam int PW = IN_W + VOL_W + 1;
  localparam int AW = PW + $clog2(NUM_SRC);
  localparam int IW = $clog2(2 * NUM_SRC);
  localparam logic signed [AW-1:0] SMAX = AW'((1 << IN_W) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, k;
  logic [NUM_SRC*IN_W-1:0] sl, sr;
  logic [NUM_SRC*VOL_W-1:0] sv;
  logic [NUM_SRC-1:0] sm;
  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [IN_W-1:0] sample;
  logic signed [VOL_W:0] gain;
  logic signed [PW-1:0] prod;
  logic is_r, last;
  logic [OUT_W-1:0] left_q, right_q;
  logic valid_q, ovr_q;
  function automatic logic [OUT_W-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] m;
    logic [OUT_W+IN_W:0] t;
    m = a >>> (VOL_W - 1);
    t = {m > SMAX ? SMAX[IN_W:0] : m < SMIN ? SMIN[IN_W:0] : m[IN_W:0], {OUT_W{1'b0}}};
    return t[OUT_W+IN_W -: OUT_W];
  endfunction
  always_comb begin
    is_r = idx >= IW'(NUM_SRC);
    k = is_r ? idx - IW'(NUM_SRC) : idx;
    last = idx == IW'(2 * NUM_SRC - 1);
    sample = is_r ? sr[k*IN_W +: IN_W] : sl[k*IN_W +: IN_W];
    gain = $signed({1'b0, sm[k] ? {VOL_W{1'b0}} : sv[k*VOL_W +: VOL_W]});
    prod = sample * gain;
    state_nx = state == IDLE ? (bus.next_sample ? MAC : IDLE) : state == MAC ? (last ? SAT : MAC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      sl <= '0;
      sr <= '0;
      sv <= '0;
      sm <= '0;
      acc_l <= '0;
      acc_r <= '0;
      left_q <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state <= state_nx;
      valid_q <= state == SAT;
      // a strobe arriving while busy is a drop; a drop outranks a same-cycle clear
      ovr_q <= (bus.next_sample && state != IDLE) || (ovr_q && !bus.overrun_clr);
      if (state == IDLE && bus.next_sample) begin
        sl <= bus.src_left;
        sr <= bus.src_right;
        sv <= bus.src_volume;
        sm <= bus.src_mute;
        acc_l <= '0;
        acc_r <= '0;
        idx <= '0;
      end
      if (state == MAC) begin
        idx <= last ? idx : idx + 1'b1;
        if (is_r) acc_r <= acc_r + prod;
        else acc_l <= acc_l + prod;
      end
      if (state == SAT) begin
        left_q <= sat(acc_l);
        right_q <= sat(acc_r);
      end
    end
  end
  assign bus.left_data = left_q;
  assign bus.right_data = right_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun = ovr_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: vector table, hand-written corner sequences and random frames against a sum-and-clamp model
module tb_audio_mixer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  audio_mixer_if bus();
  audio_mixer dut(.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [63:0] l;
    logic [63:0] r;
    logic [23:0] v;
    logic [3:0] m;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [63:0] l, input logic [63:0] r, input logic [23:0] v, input logic [3:0] m);
    bus.src_left = l;
    bus.src_right = r;
    bus.src_volume = v;
    bus.src_mute = m;
  endtask
  task automatic frame(output int lat);
    bus.next_sample = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      bus.next_sample = 1'b0;
      if (lat == 1) chk("busy_in_frame", 32'(bus.busy), 32'd1);
    end while (!bus.out_valid && lat < 40);
  endtask
  // each source scaled by vol/32, summed, floored, clamped to 17 bits, left-justified
  function automatic logic [23:0] mix(input logic [63:0] s, input logic [23:0] v, input logic [3:0] m);
    longint acc = 0;
    for (int k = 0; k < 4; k++)
      if (!m[k]) acc += longint'($signed(s[k*16 +: 16])) * longint'(v[k*6 +: 6]);
    acc = acc >>> 5;
    if (acc > 65535) acc = 65535;
    if (acc < -65536) acc = -65536;
    return 24'(acc * 128);
  endfunction
  initial begin
    int lat, vcount, early;
    logic [63:0] l, r;
    logic [23:0] v;
    logic [3:0] m;
    tbl[0] = '{64'h1000, 64'h0, 24'd32, 4'h0, 24'h080000, 24'h000000};
    tbl[1] = '{{4{16'h7FFF}}, {4{16'h8000}}, 24'hFFFFFF, 4'h0, 24'h7FFF80, 24'h800000};
    tbl[2] = '{64'hFFFF, 64'h0, 24'd16, 4'h0, 24'hFFFF80, 24'h000000};
    tbl[3] = '{64'h2000_1000, 64'h0, 24'h000820, 4'h2, 24'h080000, 24'h000000};
    tbl[4] = '{64'h2000_1000, 64'h0, 24'h000820, 4'h0, 24'h180000, 24'h000000};
    bus.next_sample = 1'b0;
    bus.overrun_clr = 1'b0;
    drive(64'h0, 64'h0, 24'h0, 4'h0);
    repeat (3) tick();
    chk("rst_left", 32'(bus.left_data), 32'h0);
    chk("rst_right", 32'(bus.right_data), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].l, tbl[i].r, tbl[i].v, tbl[i].m);
      frame(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
      chk($sformatf("vec%0d_left", i), 32'(bus.left_data), 32'(tbl[i].el));
      chk($sformatf("vec%0d_right", i), 32'(bus.right_data), 32'(tbl[i].er));
      chk($sformatf("vec%0d_idle_at_valid", i), 32'(bus.busy), 32'd0);
      tick();
      chk($sformatf("vec%0d_valid_pulse", i), 32'(bus.out_valid), 32'd0);
    end
    drive(tbl[4].l, tbl[4].r, tbl[4].v, tbl[4].m);
    bus.next_sample = 1'b1;
    early = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      bus.next_sample = 1'b0;
      if (c == 3) drive({4{16'h7FFF}}, {4{16'h7FFF}}, 24'hFFFFFF, 4'h0);
      if (c < 10 && bus.out_valid) early++;
    end
    chk("snap_early_valid", 32'(early), 32'd0);
    chk("snap_valid", 32'(bus.out_valid), 32'd1);
    chk("snap_left", 32'(bus.left_data), 32'h180000);
    tick();
    drive(tbl[0].l, tbl[0].r, tbl[0].v, tbl[0].m);
    chk("ovr_initial", 32'(bus.overrun), 32'd0);
    bus.next_sample = 1'b1;
    vcount = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.next_sample = (c == 5 || c == 10);
      if (bus.out_valid) vcount++;
      if (c == 6) chk("ovr_set", 32'(bus.overrun), 32'd1);
      if (c == 10) chk("ovr_first_valid", 32'(bus.out_valid), 32'd1);
      if (c == 20) chk("ovr_second_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.next_sample = 1'b0;
    chk("ovr_valid_count", 32'(vcount), 32'd2);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    tick();
    bus.next_sample = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.next_sample = (c == 2);
      bus.overrun_clr = (c == 2);
      if (c == 3) chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
    end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    chk("ovr_clear", 32'(bus.overrun), 32'd0);
    chk("ovr_data", 32'(bus.left_data), 32'h080000);
    bus.next_sample = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.next_sample = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midrst_left", 32'(bus.left_data), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.out_valid) vcount++;
    end
    chk("midrst_no_valid", 32'(vcount), 32'd0);
    rst = 1'b1;
    tick();
    drive(tbl[4].l, tbl[4].r, tbl[4].v, tbl[4].m);
    frame(lat);
    chk("postrst_latency", 32'(lat), 32'd10);
    chk("postrst_left", 32'(bus.left_data), 32'h180000);
    tick();
    for (int i = 0; i < 20; i++) begin
      l = {$urandom(), $urandom()};
      r = {$urandom(), $urandom()};
      v = 24'($urandom());
      m = 4'($urandom());
      drive(l, r, v, m);
      frame(lat);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd10);
      chk($sformatf("rnd%0d_left", i), 32'(bus.left_data), 32'(mix(l, v, m)));
      chk($sformatf("rnd%0d_right", i), 32'(bus.right_data), 32'(mix(r, v, m)));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
